// File: rtl/button_event_queue_pkg.sv
// Shared definitions for the button event queue: event codes and widths.
package button_event_queue_pkg;

  localparam int EVT_W = 3;
  localparam int N_EVT = 5;

  typedef enum logic [EVT_W-1:0] {
    EVT_B1_PRESS = 3'd0,
    EVT_B2_PRESS = 3'd1,
    EVT_B1_LONG  = 3'd2,
    EVT_B2_LONG  = 3'd3,
    EVT_COMBO    = 3'd4
  } evt_code_e;

endpackage

// File: rtl/button_event_queue_if.sv
// Valid/ready event stream from the button event queue to the game FSM.
interface button_event_queue_if;
  import button_event_queue_pkg::*;

  logic             evt_valid;
  logic [EVT_W-1:0] evt_code;
  logic             evt_ready;

  modport master (output evt_valid, output evt_code, input evt_ready);
  modport slave  (input evt_valid, input evt_code, output evt_ready);

endinterface

// File: rtl/button_event_queue_event_fifo.sv
// Show-ahead synchronous FIFO; a push is accepted when full only alongside a pop.
module event_fifo #(
  parameter  int DEPTH = 8,
  parameter  int EVT_W = 3,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [EVT_W-1:0] i_data,
  input  logic             i_pop,
  output logic [EVT_W-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  logic [AW:0]      r_wptr, r_rptr;
  logic [EVT_W-1:0] r_mem [DEPTH];
  logic             w_do_pop, w_do_push;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_count   = r_wptr - r_rptr;
  assign o_data    = r_mem[r_rptr[AW-1:0]];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/button_event_queue.sv
// Classifies button pulses/levels into press, long-press and combo events and queues them
// for the game FSM behind a valid/ready handshake.
module button_event_queue
  import button_event_queue_pkg::*;
#(
  parameter  int DEPTH       = 8,
  parameter  int LONG_CYCLES = 25_000_000,
  parameter  int CNT_W       = 25,
  localparam int CW          = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_b1_pulse,
  input  logic                 i_b2_pulse,
  input  logic                 i_b1_held,
  input  logic                 i_b2_held,
  input  logic                 i_ovf_clr,
  button_event_queue_if.master evt_if,
  output logic [CW-1:0]        o_evt_count,
  output logic                 o_overflow
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  logic [1:0]       w_held;
  logic [CNT_W-1:0] r_hold_cnt [2];
  logic [1:0]       r_long_done, r_long_fire;
  logic [N_EVT-1:0] r_pend, w_fire, w_grant;
  evt_code_e        w_wr_code;
  logic [EVT_W-1:0] w_head;
  logic             w_push, w_pop, w_full, w_empty, w_can_write, w_drop, r_ovf;

  assign w_held = {i_b2_held, i_b1_held};

  // The long-press source is a registered one-cycle pulse, just like the press detector outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) r_hold_cnt[i] <= '0;
      r_long_done <= '0;
      r_long_fire <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!w_held[i]) begin
          r_hold_cnt[i]  <= '0;
          r_long_done[i] <= 1'b0;
          r_long_fire[i] <= 1'b0;
        end else begin
          if (r_hold_cnt[i] != '1) r_hold_cnt[i] <= r_hold_cnt[i] + CNT_W'(1);
          r_long_fire[i] <= (r_hold_cnt[i] == LONG_LAST) && !r_long_done[i];
          if (r_hold_cnt[i] == LONG_LAST) r_long_done[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_fire               = '0;
    w_fire[EVT_COMBO]    = i_b1_pulse & i_b2_pulse;
    w_fire[EVT_B1_PRESS] = i_b1_pulse & ~i_b2_pulse;
    w_fire[EVT_B2_PRESS] = i_b2_pulse & ~i_b1_pulse;
    w_fire[EVT_B1_LONG]  = r_long_fire[0];
    w_fire[EVT_B2_LONG]  = r_long_fire[1];
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_grant   = '0;
    w_wr_code = EVT_B1_PRESS;
    if (w_can_write) begin
      if      (r_pend[EVT_COMBO])    w_wr_code = EVT_COMBO;
      else if (r_pend[EVT_B1_PRESS]) w_wr_code = EVT_B1_PRESS;
      else if (r_pend[EVT_B2_PRESS]) w_wr_code = EVT_B2_PRESS;
      else if (r_pend[EVT_B1_LONG])  w_wr_code = EVT_B1_LONG;
      else                           w_wr_code = EVT_B2_LONG;
      w_grant[w_wr_code] = |r_pend;
    end
  end

  assign w_push      = |w_grant;
  assign w_pop       = !w_empty && evt_if.evt_ready;
  assign w_can_write = !w_full || w_pop;
  assign w_drop      = |(w_fire & r_pend & ~w_grant);

  // A flag granted and re-fired on the same edge stays set; only an un-granted flag drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~w_grant) | w_fire;
      if (w_drop)         r_ovf <= 1'b1;
      else if (i_ovf_clr) r_ovf <= 1'b0;
    end
  end

  event_fifo #(
    .DEPTH (DEPTH),
    .EVT_W (EVT_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_wr_code),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (o_evt_count)
  );

  assign evt_if.evt_valid = !w_empty;
  assign evt_if.evt_code  = w_head;
  assign o_overflow       = r_ovf;

endmodule

// File: tb/tb_button_event_queue.sv
// Directed and randomized checks of button_event_queue against an event-level reference model.
module tb_button_event_queue;
  import button_event_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int LONG  = 16;
  localparam int CNT_W = 5;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          b1p, b2p, b1h, b2h, ovf_clr;
  logic [CW-1:0] evt_count;
  logic          overflow;

  button_event_queue_if evt_if ();

  button_event_queue #(
    .DEPTH       (DEPTH),
    .LONG_CYCLES (LONG),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_b1_pulse  (b1p),
    .i_b2_pulse  (b2p),
    .i_b1_held   (b1h),
    .i_b2_held   (b2h),
    .i_ovf_clr   (ovf_clr),
    .evt_if      (evt_if),
    .o_evt_count (evt_count),
    .o_overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Reference model: a queue of codes, one pending bit per code, and the length of each
  // button's current hold. A long press is due on the hold's LONG-th sampled cycle and
  // reaches the pending stage one cycle later.
  int m_q[$];
  bit m_pend[N_EVT];
  int m_run[2];
  bit m_long_due[2];
  bit m_ovf;
  int prio[N_EVT] = '{4, 0, 1, 2, 3};

  int obs[$];
  int peak;

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < N_EVT; i++) m_pend[i] = 1'b0;
    for (int x = 0; x < 2; x++) begin
      m_run[x]      = 0;
      m_long_due[x] = 1'b0;
    end
    m_ovf = 1'b0;
  endtask

  task automatic model_edge();
    bit pop;
    bit drop;
    int g;
    bit fire[N_EVT];
    bit held[2];
    pop = (m_q.size() > 0) && evt_if.evt_ready;
    g   = -1;
    if (m_q.size() < DEPTH || pop)
      for (int k = 0; k < N_EVT; k++)
        if (g < 0 && m_pend[prio[k]]) g = prio[k];
    fire[4] = b1p && b2p;
    fire[0] = b1p && !b2p;
    fire[1] = b2p && !b1p;
    fire[2] = m_long_due[0];
    fire[3] = m_long_due[1];
    drop = 1'b0;
    for (int i = 0; i < N_EVT; i++) begin
      if (fire[i] && m_pend[i] && i != g) drop = 1'b1;
      m_pend[i] = (m_pend[i] && i != g) || fire[i];
    end
    if (pop) void'(m_q.pop_front());
    if (g >= 0) m_q.push_back(g);
    if (drop) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    held[0] = b1h;
    held[1] = b2h;
    for (int x = 0; x < 2; x++) begin
      m_run[x]      = held[x] ? m_run[x] + 1 : 0;
      m_long_due[x] = held[x] && (m_run[x] == LONG);
    end
  endtask

  task automatic compare();
    check("valid", evt_if.evt_valid, m_q.size() > 0);
    if (m_q.size() > 0) check("code", evt_if.evt_code, m_q[0]);
    check("count", evt_count, m_q.size());
    check("overflow", overflow, m_ovf);
    if (int'(evt_count) > peak) peak = int'(evt_count);
  endtask

  // Inputs are set after a falling edge; one call covers the next rising edge and the check after it.
  task automatic cycle();
    if (evt_if.evt_valid && evt_if.evt_ready) obs.push_back(int'(evt_if.evt_code));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    #1;
    check({tag, "_valid"}, evt_if.evt_valid, 0);
    check({tag, "_count"}, evt_count, 0);
    check({tag, "_ovf"}, overflow, 0);
    model_reset();
    {b1p, b2p, b1h, b2h, ovf_clr} = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic int count_code(input int code);
    int n = 0;
    foreach (obs[i]) if (obs[i] == code) n++;
    return n;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int bias;
    reset = 1'b0;
    {b1p, b2p, b1h, b2h, ovf_clr} = '0;
    evt_if.evt_ready = 1'b0;
    model_reset();
    #3;
    check("reset_valid", evt_if.evt_valid, 0);
    check("reset_count", evt_count, 0);
    check("reset_ovf", overflow, 0);
    @(negedge clk);
    reset = 1'b1;
    cycle();

    // Single press: visible exactly two edges after the pulse, for one cycle.
    evt_if.evt_ready = 1'b1;
    b1p = 1'b1;
    cycle();
    check("t1_valid_edge1", evt_if.evt_valid, 0);
    b1p = 1'b0;
    cycle();
    check("t1_valid_edge2", evt_if.evt_valid, 1);
    check("t1_code", evt_if.evt_code, EVT_B1_PRESS);
    cycle();
    check("t1_valid_edge3", evt_if.evt_valid, 0);

    // Combo.
    obs.delete();
    peak = 0;
    b1p = 1'b1;
    b2p = 1'b1;
    cycle();
    {b1p, b2p} = '0;
    repeat (5) cycle();
    check("t2_events", obs.size(), 1);
    check("t2_code", obs.size() > 0 ? obs[0] : -1, EVT_COMBO);
    check("t2_peak", peak, 1);

    // Long press on button 2, then a second hold.
    obs.delete();
    lat = -1;
    b2h = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      cycle();
      if (lat < 0 && evt_if.evt_valid && evt_if.evt_code == EVT_B2_LONG) lat = k;
    end
    check("t3_latency", lat, LONG + 2);
    check("t3_first_hold", count_code(EVT_B2_LONG), 1);
    b2h = 1'b0;
    repeat (5) cycle();
    obs.delete();
    b2h = 1'b1;
    repeat (20) cycle();
    b2h = 1'b0;
    repeat (3) cycle();
    check("t3_second_hold", count_code(EVT_B2_LONG), 1);

    // Backpressure, then a drop.
    evt_if.evt_ready = 1'b0;
    obs.delete();
    for (int p = 0; p < 5; p++) begin
      b1p = 1'b1;
      cycle();
      b1p = 1'b0;
      repeat (2) cycle();
    end
    check("t4_full_count", evt_count, DEPTH);
    check("t4_no_ovf", overflow, 0);
    b1p = 1'b1;
    cycle();
    b1p = 1'b0;
    cycle();
    check("t4_ovf", overflow, 1);
    evt_if.evt_ready = 1'b1;
    repeat (10) cycle();
    check("t4_drained", obs.size(), 5);
    check("t4_all_b1", count_code(EVT_B1_PRESS), 5);
    check("t4_ovf_sticky", overflow, 1);
    ovf_clr = 1'b1;
    cycle();
    ovf_clr = 1'b0;
    check("t4_ovf_clr", overflow, 0);

    // Press and long-press arriving together.
    obs.delete();
    b2h = 1'b1;
    repeat (LONG) cycle();
    b1p = 1'b1;
    cycle();
    b1p = 1'b0;
    repeat (6) cycle();
    b2h = 1'b0;
    cycle();
    check("t5_events", obs.size(), 2);
    check("t5_first", obs.size() > 0 ? obs[0] : -1, EVT_B1_PRESS);
    check("t5_second", obs.size() > 1 ? obs[1] : -1, EVT_B2_LONG);

    // Reset with entries queued.
    evt_if.evt_ready = 1'b0;
    for (int p = 0; p < 3; p++) begin
      b1p = 1'b1;
      cycle();
      b1p = 1'b0;
      repeat (2) cycle();
    end
    check("t6_count_before", evt_count, 3);
    async_reset("t6");
    cycle();
    check("t6_ovf_after", overflow, 0);

    // Randomized traffic checked every cycle against the model.
    bias = 3;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) bias = int'($urandom_range(0, 4));
      b1p     = ($urandom_range(0, 9) == 0);
      b2p     = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 29) == 0) b1h = ~b1h;
      if ($urandom_range(0, 29) == 0) b2h = ~b2h;
      evt_if.evt_ready = ($urandom_range(0, 4) < bias);
      ovf_clr = ($urandom_range(0, 49) == 0);
      if (c == 1500) async_reset("rand_rst");
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
